pipe_sreg: RTL and testbench

Parametrised pipeline stage register for the MIPS datapath, the successor to the single-word stage register. It holds a WIDTH-bit payload between two pipeline stages with a valid/ready handshake, a synchronous flush for branch/exception squash, and an optional two-entry skid buffer so the upstream ready is driven directly from a flop. Stage boundaries such as IF/ID and ID/EX instantiate it so that stall and flush are handled in one place.

---
 rtl/pipe_sreg_if.sv | 24 ++
 rtl/pipe_sreg.sv | 97 +++++++++
 tb/tb_pipe_sreg.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_sreg_if.sv
// Handshake bundle between two pipeline stages around a pipe_sreg.
// The master side is upstream/downstream logic; the slave side is the stage register.
interface pipe_sreg_if #(
  parameter int WIDTH = 32
);
  logic             flush;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [1:0]       count;

  modport master (
    output flush, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  flush, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
endinterface

// File: rtl/pipe_sreg.sv
// Pipeline stage register with valid/ready handshake and synchronous flush; state moves on the falling clock edge.
// Define PIPE_SREG_SKID_EN to add the skid entry so in_ready comes straight from a flop.
module pipe_sreg #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input logic       clk,
  input logic       rst,
  pipe_sreg_if.slave bus
);

  logic [WIDTH-1:0] m_data, m_data_nxt;
  logic             m_vld, m_vld_nxt;
  logic             s_vld;
  logic             push, pop;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = m_vld && bus.out_ready;

`ifdef PIPE_SREG_SKID_EN
  logic [WIDTH-1:0] s_data, s_data_nxt;
  logic             s_vld_nxt;

  assign bus.in_ready = !s_vld;

  always_comb begin
    m_data_nxt = m_data;
    m_vld_nxt  = m_vld;
    s_data_nxt = s_data;
    s_vld_nxt  = s_vld;
    if (!m_vld) begin
      if (push) begin
        m_data_nxt = bus.in_data;
        m_vld_nxt  = 1'b1;
      end
    end else if (!s_vld) begin
      if (push && pop) begin
        m_data_nxt = bus.in_data;
      end else if (push) begin
        s_data_nxt = bus.in_data;
        s_vld_nxt  = 1'b1;
      end else if (pop) begin
        m_vld_nxt  = 1'b0;
      end
    end else if (pop) begin
      // both full: upstream is stalled, so only the skid entry can advance
      m_data_nxt = s_data;
      s_vld_nxt  = 1'b0;
    end
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      s_data <= RESET_DATA;
      s_vld  <= 1'b0;
    end else if (bus.flush) begin
      s_data <= RESET_DATA;
      s_vld  <= 1'b0;
    end else begin
      s_data <= s_data_nxt;
      s_vld  <= s_vld_nxt;
    end
  end
`else
  assign s_vld        = 1'b0;
  assign bus.in_ready = !m_vld || bus.out_ready;

  always_comb begin
    m_data_nxt = m_data;
    m_vld_nxt  = m_vld;
    if (push) begin
      m_data_nxt = bus.in_data;
      m_vld_nxt  = 1'b1;
    end else if (pop) begin
      m_vld_nxt  = 1'b0;
    end
  end
`endif

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      m_data <= RESET_DATA;
      m_vld  <= 1'b0;
    end else if (bus.flush) begin
      m_data <= RESET_DATA;
      m_vld  <= 1'b0;
    end else begin
      m_data <= m_data_nxt;
      m_vld  <= m_vld_nxt;
    end
  end

  assign bus.out_valid = m_vld;
  assign bus.out_data  = m_vld ? m_data : '0;
  assign bus.count     = {1'b0, m_vld} + {1'b0, s_vld};

endmodule

// File: tb/tb_pipe_sreg.sv
// Self-checking bench for pipe_sreg: queue-based FIFO model plus directed literal checks, at WIDTH 32, 64 and 1.
module tb_pipe_sreg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  pipe_sreg_if #(32) b();
  pipe_sreg_if #(64) b64();
  pipe_sreg_if #(1)  b1();

  assign b64.flush     = b.flush;
  assign b64.in_valid  = b.in_valid;
  assign b64.in_data   = {b.in_data, ~b.in_data};
  assign b64.out_ready = b.out_ready;
  assign b1.flush      = b.flush;
  assign b1.in_valid   = b.in_valid;
  assign b1.in_data    = b.in_data[0];
  assign b1.out_ready  = b.out_ready;

  pipe_sreg #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(b));
  pipe_sreg #(.WIDTH(64), .RESET_DATA({64{1'b1}})) dut64 (.clk(clk), .rst(rst), .bus(b64));
  pipe_sreg #(.WIDTH(1), .RESET_DATA(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  int n_cmp = 0;
  int n_err = 0;
  bit seen_db = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  logic [31:0] q[$];

  function automatic bit exp_ready();
    if (!rst) return 1'b1;
`ifdef PIPE_SREG_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || b.out_ready;
`endif
  endfunction

  always @(negedge clk) begin
    bit pu, po;
    if (!rst || b.flush) begin
      q.delete();
    end else begin
      pu = b.in_valid && exp_ready();
      po = (q.size() > 0) && b.out_ready;
      if (po) void'(q.pop_front());
      if (pu) q.push_back(b.in_data);
    end
  end

  logic        ev;
  logic [31:0] ed;
  logic [1:0]  ec;
  always @(posedge clk) begin
    #2;
    ev = rst && (q.size() > 0);
    ed = ev ? q[0] : 32'h0;
    ec = rst ? 2'(q.size()) : 2'd0;
    chk("out_valid", 64'(b.out_valid), 64'(ev));
    chk("out_data", 64'(b.out_data), 64'(ed));
    chk("count", 64'(b.count), 64'(ec));
    chk("in_ready", 64'(b.in_ready), 64'(exp_ready()));
    chk("w64_out_data", b64.out_data, ev ? {ed, ~ed} : 64'h0);
    chk("w64_count", 64'(b64.count), 64'(ec));
    chk("w1_out_data", 64'(b1.out_data), 64'(ev ? ed[0] : 1'b0));
    chk("w1_out_valid", 64'(b1.out_valid), 64'(ev));
    if (b.out_valid && b.out_data == 32'hDEAD_BEEF) seen_db = 1'b1;
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    @(posedge clk);
    #1;
    b.in_valid  = v;
    b.in_data   = d;
    b.out_ready = r;
    b.flush     = f;
  endtask

  initial begin
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0; b.flush = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_m64_all_ones", dut64.m_data, {64{1'b1}});
    chk("rst_m1_one", 64'(dut1.m_data), 64'h1);
    chk("rst_w64_out_zero", b64.out_data, 64'h0);
    chk("rst_in_ready", 64'(b.in_ready), 64'h1);
    @(posedge clk); #1; rst = 1'b1;

    // mid-stream reset
    drive(1'b1, 32'h11, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
`ifdef PIPE_SREG_SKID_EN
    chk("pre_rst_count", 64'(b.count), 64'd2);
`else
    chk("pre_rst_count", 64'(b.count), 64'd1);
`endif
    #1; rst = 1'b0; #1;
    chk("rst_out_valid", 64'(b.out_valid), 64'h0);
    chk("rst_out_data", 64'(b.out_data), 64'h0);
    chk("rst_count", 64'(b.count), 64'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b1, 32'h0000_00A5, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("after_rst_push", 64'(b.out_data), 64'hA5);
    drive(1'b0, 32'h0, 1'b0, 1'b1);

    // streaming
    for (int k = 1; k <= 17; k++) begin
      drive(k <= 16, 32'(k), 1'b1, 1'b0);
      #1;
      if (k >= 2) begin
        chk("stream_data", 64'(b.out_data), 64'(k - 1));
        chk("stream_count", 64'(b.count), 64'd1);
      end
    end

`ifdef PIPE_SREG_SKID_EN
    drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
    drive(1'b1, 32'hAAAA_0002, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("bp_count", 64'(b.count), 64'd2);
    chk("bp_in_ready", 64'(b.in_ready), 64'd0);
    chk("bp_out_data", 64'(b.out_data), 64'hAAAA_0001);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("bp_pop1", 64'(b.out_data), 64'hAAAA_0001);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("bp_pop2", 64'(b.out_data), 64'hAAAA_0002);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("bp_empty", 64'(b.count), 64'd0);
`else
    drive(1'b1, 32'h33, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("bp_in_ready_low", 64'(b.in_ready), 64'd0);
    drive(1'b1, 32'h55, 1'b1, 1'b0);
    #1;
    chk("bp_in_ready_comb", 64'(b.in_ready), 64'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("bp_m_55", 64'(b.out_data), 64'h55);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
`endif

    // flush collision
    drive(1'b1, 32'h0BAD_0001, 1'b0, 1'b0);
    drive(1'b1, 32'h0BAD_0002, 1'b0, 1'b0);
    seen_db = 1'b0;
    drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("flush_count", 64'(b.count), 64'd0);
    chk("flush_out_valid", 64'(b.out_valid), 64'd0);
    chk("flush_out_data", 64'(b.out_data), 64'd0);
    repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0);
    #3;
    chk("flush_never_out", 64'(seen_db), 64'd0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
            $urandom_range(0, 15) == 0);
    end
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    repeat (3) drive(1'b0, 32'h0, 1'b1, 1'b0);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
